// File: rtl/complex_matrix_serializer_pkg.sv
// Shared types and constants for the complex matrix serializer.
// Sideband bit positions match the adder's full-matrix stream.
package complex_matrix_serializer_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_e;

  localparam int TUSER_EOM = 2;
  localparam int TUSER_A   = 1;
  localparam int TUSER_B   = 0;

  // The element index needs at least one bit, even for a single-element matrix.
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/complex_matrix_serializer.sv
// Buffers one whole matrix per s_axis beat and replays it one element per m_axis beat, row-major.
// Element 0 appears the cycle after capture; the next matrix is taken on the final-beat handshake.
module complex_matrix_serializer
  import complex_matrix_serializer_pkg::*;
#(
  parameter  int MAT_WIDTH    = 4,
  parameter  int MAT_HEIGHT   = 4,
  parameter  int ELEMENT_SIZE = 16,
  localparam int N            = MAT_WIDTH * MAT_HEIGHT,
  localparam int IDX_W        = idx_width(N)
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [N*ELEMENT_SIZE-1:0]   s_axis_tdata,
  input  logic                        s_axis_tvalid,
  output logic                        s_axis_tready,
  input  logic                        s_axis_tlast,
  input  logic [1:0]                  s_axis_tuser,
  output logic [ELEMENT_SIZE-1:0]     m_axis_tdata,
  output logic                        m_axis_tvalid,
  input  logic                        m_axis_tready,
  output logic                        m_axis_tlast,
  output logic [2:0]                  m_axis_tuser,
  output logic [IDX_W-1:0]            m_axis_tindex
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);
  localparam logic             ONE_ELEM = (N == 1);

  state_e                    state_q, state_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic [N*ELEMENT_SIZE-1:0] buf_q, buf_d;
  logic [1:0]                tuser_q, tuser_d;
  logic                      tlast_q, tlast_d;
  logic [ELEMENT_SIZE-1:0]   m_dat_q, m_dat_d;
  logic [2:0]                m_user_q, m_user_d;
  logic                      m_last_q, m_last_d;

  logic             beat;
  logic             last_beat;
  logic             cap;
  logic             nxt_last;
  logic [IDX_W-1:0] nxt_idx;

  always_comb begin
    beat          = (state_q == ST_SEND) & m_axis_tready;
    last_beat     = beat & (idx_q == LAST_IDX);
    // Opening the input only on the final beat keeps an unsent buffer from being overwritten.
    s_axis_tready = reset_n & ((state_q == ST_IDLE) | last_beat);
    cap           = s_axis_tvalid & s_axis_tready;
    nxt_idx       = idx_q + IDX_W'(1);
    nxt_last      = (nxt_idx == LAST_IDX);

    state_d  = state_q;
    idx_d    = idx_q;
    buf_d    = buf_q;
    tuser_d  = tuser_q;
    tlast_d  = tlast_q;
    m_dat_d  = m_dat_q;
    m_user_d = m_user_q;
    m_last_d = m_last_q;

    if (cap) begin
      state_d             = ST_SEND;
      idx_d               = '0;
      buf_d               = s_axis_tdata;
      tuser_d             = s_axis_tuser;
      tlast_d             = s_axis_tlast;
      m_dat_d             = s_axis_tdata[ELEMENT_SIZE-1:0];
      m_user_d            = '0;
      m_user_d[TUSER_EOM] = ONE_ELEM;
      m_user_d[TUSER_A]   = s_axis_tuser[1];
      m_user_d[TUSER_B]   = s_axis_tuser[0];
      m_last_d            = ONE_ELEM & s_axis_tlast;
    end else if (last_beat) begin
      state_d  = ST_IDLE;
      idx_d    = '0;
      m_dat_d  = '0;
      m_user_d = '0;
      m_last_d = 1'b0;
    end else if (beat) begin
      idx_d               = nxt_idx;
      m_dat_d             = buf_q[nxt_idx*ELEMENT_SIZE +: ELEMENT_SIZE];
      m_user_d            = '0;
      m_user_d[TUSER_EOM] = nxt_last;
      m_user_d[TUSER_A]   = tuser_q[1];
      m_user_d[TUSER_B]   = tuser_q[0];
      m_last_d            = nxt_last & tlast_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      buf_q    <= '0;
      tuser_q  <= '0;
      tlast_q  <= 1'b0;
      m_dat_q  <= '0;
      m_user_q <= '0;
      m_last_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      buf_q    <= buf_d;
      tuser_q  <= tuser_d;
      tlast_q  <= tlast_d;
      m_dat_q  <= m_dat_d;
      m_user_q <= m_user_d;
      m_last_q <= m_last_d;
    end
  end

  assign m_axis_tvalid = (state_q == ST_SEND);
  assign m_axis_tdata  = m_dat_q;
  assign m_axis_tuser  = m_user_q;
  assign m_axis_tlast  = m_last_q;
  assign m_axis_tindex = idx_q;

endmodule
